// File: rtl/eb1_iccm_loader.sv
// rtl/eb1_iccm_loader.sv - assembles UART bytes into words and writes them to the ICCM
// Optional end-of-image checksum word: define ICCM_LOADER_CHECKSUM_EN.
module eb1_iccm_loader #(
   parameter int unsigned       ADDR_W         = 14,
   parameter int unsigned       BYTES_PER_WORD = 4,
   parameter int unsigned       ADDR_STEP      = 1,
   parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
   parameter logic [63:0]       END_WORD       = 64'h0000_0FFF,
   parameter int unsigned       TIMEOUT_CYC    = 65535,
   localparam int unsigned      DATA_W         = 8 * BYTES_PER_WORD
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rx_dv_i,
   input  logic [7:0]        rx_byte_i,
   output logic              we_o,
   input  logic              wr_ready_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              load_done_o,
   output logic              busy_o,
   output logic [2:0]        err_o,
   output logic [ADDR_W-1:0] word_cnt_o
);
   localparam int unsigned       BC_W      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int unsigned       GAP_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [DATA_W-1:0] END_W     = DATA_W'(END_WORD);
   localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

`ifdef ICCM_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {COLLECT = 2'd0, WRITE = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_e;
`else
   typedef enum logic [1:0] {COLLECT = 2'd0, WRITE = 2'd1, DONE = 2'd3} state_e;
`endif

   state_e            state_q, state_d;
   logic [BC_W-1:0]   byte_cnt_q;
   logic [GAP_W-1:0]  gap_q;
   logic [1:0]        err_q;
   logic              collecting, rx_take, word_done, timeout_hit, handshake;
   logic [DATA_W-1:0] asm_word;

   always_comb begin
      collecting = (state_q == COLLECT);
`ifdef ICCM_LOADER_CHECKSUM_EN
      collecting = collecting || (state_q == CHECK);
`endif
      rx_take     = rx_dv_i && collecting;
      asm_word    = (wdata_o << 8) | DATA_W'(rx_byte_i);
      word_done   = rx_take && (byte_cnt_q == LAST_BYTE);
      // an arriving byte always beats an expiring gap counter
      timeout_hit = (TIMEOUT_CYC != 0) && collecting && !rx_dv_i &&
                    (byte_cnt_q != '0) && (gap_q == GAP_LAST);
      handshake   = (state_q == WRITE) && wr_ready_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= COLLECT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: begin
            if (word_done) begin
               if (asm_word == END_W) begin
`ifdef ICCM_LOADER_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = DONE;
`endif
               end else begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: if (handshake) state_d = COLLECT;
`ifdef ICCM_LOADER_CHECKSUM_EN
         CHECK: if (word_done) state_d = DONE;
`endif
         DONE:    state_d = DONE;
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         byte_cnt_q <= '0;
         gap_q      <= '0;
         wdata_o    <= '0;
         addr_o     <= BASE_ADDR;
         word_cnt_o <= '0;
         err_q      <= '0;
      end else begin
         if (rx_take) begin
            gap_q      <= '0;
            wdata_o    <= asm_word;
            byte_cnt_q <= word_done ? '0 : byte_cnt_q + BC_W'(1);
         end else if (timeout_hit) begin
            gap_q      <= '0;
            wdata_o    <= '0;
            byte_cnt_q <= '0;
            err_q[1]   <= 1'b1;
         end else if (collecting && (byte_cnt_q != '0) && (TIMEOUT_CYC != 0)) begin
            gap_q <= gap_q + GAP_W'(1);
         end
         // bytes cannot be buffered while a write is outstanding
         if ((state_q == WRITE) && rx_dv_i) err_q[0] <= 1'b1;
         if (handshake) begin
            addr_o     <= addr_o + STEP;
            word_cnt_o <= word_cnt_o + ADDR_W'(1);
         end
      end
   end

`ifdef ICCM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;
   logic              sum_err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sum_q     <= '0;
         sum_err_q <= 1'b0;
      end else begin
         if (handshake) sum_q <= sum_q + wdata_o;
         if ((state_q == CHECK) && word_done && (asm_word != sum_q)) sum_err_q <= 1'b1;
      end
   end

   assign err_o = {sum_err_q, err_q};
`else
   assign err_o = {1'b0, err_q};
`endif

   assign we_o        = (state_q == WRITE);
   assign load_done_o = (state_q == DONE);
   assign busy_o      = (byte_cnt_q != '0) || (state_q == WRITE);

endmodule

// File: tb/tb_eb1_iccm_loader.sv
// tb/tb_eb1_iccm_loader.sv - scoreboard bench for eb1_iccm_loader against a byte-level image model
module tb_eb1_iccm_loader;
   localparam int          T_OUT = 16;
   localparam logic [31:0] END_W = 32'h0000_0FFF;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rx_dv_i;
   logic [7:0]  rx_byte_i;
   logic        we_o;
   logic        wr_ready_i;
   logic [13:0] addr_o;
   logic [31:0] wdata_o;
   logic        load_done_o;
   logic        busy_o;
   logic [2:0]  err_o;
   logic [13:0] word_cnt_o;

   eb1_iccm_loader #(.TIMEOUT_CYC(T_OUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .rx_dv_i(rx_dv_i), .rx_byte_i(rx_byte_i),
      .we_o(we_o), .wr_ready_i(wr_ready_i), .addr_o(addr_o), .wdata_o(wdata_o),
      .load_done_o(load_done_o), .busy_o(busy_o), .err_o(err_o), .word_cnt_o(word_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [45:0] exp_q[$];
   logic [45:0] exp_e;
   logic [13:0] m_addr, m_cnt;
   logic [31:0] m_word, m_sum;
   int          m_nbytes, m_last_edge;
   logic [2:0]  m_err;
   bit          m_check, m_done;

   logic rand_ready = 1'b0, ready_force = 1'b1, rnd_rdy = 1'b1;
   assign wr_ready_i = rand_ready ? rnd_rdy : ready_force;

   int          we_run = 0, last_run = 0;
   logic [13:0] held_addr;
   logic [31:0] held_data;

   always @(posedge clk_i) cyc = cyc + 1;
   always @(posedge clk_i) begin
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // monitor: every write handshake must match the next expected word
   always @(negedge clk_i) begin
      if (rst_i) begin
         we_run = 0;
      end else if (we_o) begin
         if (we_run > 0) begin
            chk("stall_addr", 64'(addr_o), 64'(held_addr));
            chk("stall_data", 64'(wdata_o), 64'(held_data));
         end
         held_addr = addr_o;
         held_data = wdata_o;
         we_run++;
         if (wr_ready_i) begin
            last_run = we_run;
            we_run   = 0;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr=%0h data=%0h required=none", addr_o, wdata_o);
            end else begin
               exp_e = exp_q.pop_front();
               if (addr_o !== exp_e[45:32] || wdata_o !== exp_e[31:0]) begin
                  errors++;
                  $display("FAIL write actual=%0h@%0h required=%0h@%0h",
                           wdata_o, addr_o, exp_e[31:0], exp_e[45:32]);
               end
            end
         end
      end
   end

   task automatic model_reset();
      m_addr = '0; m_cnt = '0; m_word = '0; m_sum = '0;
      m_nbytes = 0; m_last_edge = 0; m_err = '0; m_check = 0; m_done = 0;
      exp_q.delete();
   endtask

   // idle edges since the last accepted byte, up to and including edge e
   task automatic model_settle(input int e);
      if (!m_done && m_nbytes > 0 && (e - m_last_edge) >= T_OUT) begin
         m_nbytes = 0;
         m_err[1] = 1'b1;
      end
   endtask

   task automatic model_byte(input logic [7:0] b, input int e);
      if (m_done) return;
      model_settle(e - 1);
      m_last_edge = e;
      m_word = {m_word[23:0], b};
      m_nbytes++;
      if (m_nbytes == 4) begin
         m_nbytes = 0;
         if (m_check) begin
            if (m_word != m_sum) m_err[2] = 1'b1;
            m_done = 1;
         end else if (m_word == END_W) begin
`ifdef ICCM_LOADER_CHECKSUM_EN
            m_check = 1;
`else
            m_done = 1;
`endif
         end else begin
            exp_q.push_back({m_addr, m_word});
            m_addr = m_addr + 14'd1;
            m_cnt  = m_cnt + 14'd1;
            m_sum  = m_sum + m_word;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic drive_byte(input logic [7:0] b);
      rx_dv_i   = 1'b1;
      rx_byte_i = b;
      @(posedge clk_i);
      #1;
      rx_dv_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (we_o && n < 200) begin
         idle(1);
         n++;
      end
      if (we_o) begin
         checks++;
         errors++;
         $display("FAIL write_drain we_o=1 required=0");
      end
      drive_byte(b);
      model_byte(b, cyc);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   task automatic settle_and_check(input string tag);
      int n = 0;
      while ((we_o || exp_q.size() != 0) && n < 200) begin
         idle(1);
         n++;
      end
      chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
      model_settle(cyc);
      chk({tag, "_addr"}, 64'(addr_o), 64'(m_addr));
      chk({tag, "_word_cnt"}, 64'(word_cnt_o), 64'(m_cnt));
      chk({tag, "_err"}, 64'(err_o), 64'(m_err));
      chk({tag, "_done"}, 64'(load_done_o), 64'(m_done));
      chk({tag, "_busy"}, 64'(busy_o), 64'(m_nbytes != 0));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_we"}, 64'(we_o), 64'd0);
      chk({tag, "_addr"}, 64'(addr_o), 64'd0);
      chk({tag, "_wdata"}, 64'(wdata_o), 64'd0);
      chk({tag, "_done"}, 64'(load_done_o), 64'd0);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_err"}, 64'(err_o), 64'd0);
      chk({tag, "_word_cnt"}, 64'(word_cnt_o), 64'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      idle(2);
      rst_i = 1'b0;
      model_reset();
      idle(1);
   endtask

   initial begin
      rst_i = 1'b1; rx_dv_i = 1'b0; rx_byte_i = '0;
      model_reset();
      idle(3);
      check_reset("in_reset");
      rst_i = 1'b0;
      idle(1);
      check_reset("post_reset");

      send_word(32'hDEAD_BEEF);
      settle_and_check("first_word");

      ready_force = 1'b0;
      send_word(32'h0102_0304);
      idle(5);
      ready_force = 1'b1;
      idle(1);
      chk("stall_we_cycles", 64'(last_run), 64'd6);
      send_word(32'hA5A5_5A5A);
      settle_and_check("stall");

      ready_force = 1'b0;
      send_word(32'hCAFE_F00D);
      drive_byte(8'h99);
      m_err[0] = 1'b1;
      idle(2);
      ready_force = 1'b1;
      send_word(32'h1234_5678);
      settle_and_check("overrun");

      ready_force = 1'b0;
      send_word(32'h5555_AAAA);
      idle(1);
      do_reset();
      ready_force = 1'b1;
      check_reset("reset_mid_write");

      send_byte(8'h11);
      send_byte(8'h22);
      idle(T_OUT);
      send_word(32'h3344_5566);
      settle_and_check("timeout");
      chk("timeout_err_value", 64'(err_o), 64'd2);
      send_byte(8'h77);
      idle(T_OUT - 1);
      send_byte(8'h88);
      send_byte(8'h99);
      send_byte(8'hAA);
      settle_and_check("gap_below_limit");

      rand_ready = 1'b1;
      for (int w = 0; w < 30; w++) begin
         logic [31:0] rw;
         rw = $urandom;
         for (int i = 3; i >= 0; i--) begin
            if ($urandom_range(0, 19) == 0) idle(T_OUT + $urandom_range(0, 4));
            else idle($urandom_range(0, 2));
            send_byte(rw[8*i +: 8]);
         end
      end
      idle(T_OUT + 2);
      settle_and_check("random");

      send_word(END_W);
`ifdef ICCM_LOADER_CHECKSUM_EN
      send_word(m_sum);
`endif
      settle_and_check("end_of_image");
      send_word(32'h1357_9BDF);
      settle_and_check("after_done");
      do_reset();
      check_reset("reset_after_done");

      rand_ready = 1'b0;
      send_word(32'h0000_0001);
      send_word(32'h0000_0002);
      send_word(END_W);
      send_word(32'h0000_0003);
      settle_and_check("checksum_good");
      do_reset();
      send_word(32'h0000_0001);
      send_word(32'h0000_0002);
      send_word(END_W);
      send_word(32'h0000_0004);
      settle_and_check("checksum_bad");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time_limit_reached required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/eb1_iccm_loader.md
# eb1_iccm_loader

Parametrised byte-stream-to-memory loader sitting between the UART receiver and the ICCM write port. It assembles received bytes into BYTES_PER_WORD-byte words and writes them to consecutive addresses through a ready/valid write port that can stall. It detects an end-of-image word and then raises a sticky load-done flag that releases the core. It adds inter-byte timeout recovery, overrun detection and an optional image checksum.

## Interface
- ADDR_W, 14: write address width
- BYTES_PER_WORD, 4: bytes per memory word; DATA_W = 8*BYTES_PER_WORD
- ADDR_STEP, 1: address increment per accepted write
- BASE_ADDR, 0: first write address
- END_WORD, 'h00000FFF (zero-extended to DATA_W): end-of-image marker
- TIMEOUT_CYC, 65535: inter-byte gap limit in cycles; 0 disables the timeout
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- rx_dv_i  in  1  rx_byte_i valid, single-cycle pulse per byte
- rx_byte_i  in  8  received byte
- we_o  out  1  write request; held until accepted
- wr_ready_i  in  1  memory accepts the write when we_o and wr_ready_i are both high
- addr_o  out  ADDR_W  write address
- wdata_o  out  DATA_W  write data
- load_done_o  out  1  sticky; image complete
- busy_o  out  1  partial word held or write pending
- err_o  out  3  sticky: [0] overrun, [1] timeout, [2] checksum mismatch
- word_cnt_o  out  ADDR_W  number of words written

## Operation
- States: COLLECT, WRITE, CHECK (only with the macro), DONE.
- COLLECT: each rx_dv_i byte is shifted in MSB-first. The first byte lands in wdata[DATA_W-1:DATA_W-8]. byte_cnt increments.
- On the BYTES_PER_WORD-th byte, byte_cnt returns to 0 and the assembled word is examined:
  - word == END_WORD: no write. Go to CHECK with the macro, to DONE without it.
  - otherwise: go to WRITE.
- WRITE: we_o=1 with stable addr_o/wdata_o. On the handshake cycle:
  - addr += ADDR_STEP, wrapping modulo 2^ADDR_W
  - word_cnt increments
  - next state is COLLECT
- An rx_dv_i byte arriving in WRITE is dropped and sets err_o[0]. The pending write is unaffected.
- Timeout: in COLLECT with byte_cnt != 0, a gap counter counts cycles without rx_dv_i. When it reaches TIMEOUT_CYC:
  - the partial word is discarded and byte_cnt goes to 0
  - err_o[1] is set
  - the address is unchanged
  - the counter clears on every accepted byte.
- DONE: load_done_o=1 and all bytes are ignored. Only rst_i leaves DONE.
- busy_o = (byte_cnt != 0) | (state == WRITE) | (state == CHECK && byte_cnt != 0).
- Reset values: state COLLECT, we_o 0, addr_o BASE_ADDR, wdata_o 0, load_done_o 0, busy_o 0, err_o 0, word_cnt_o 0, byte_cnt 0, gap counter 0.
- Reset asserted mid-word or mid-write aborts immediately. A pending write is not completed.

## Timing
- The final byte is sampled at edge N. At edge N+1, wdata_o is valid and, for a data word, we_o=1 in the same cycle.
- With wr_ready_i high, we_o is high for exactly one cycle. A stall holds we_o, addr_o and wdata_o unchanged.
- addr_o and word_cnt_o update on the edge that ends the handshake cycle.
- load_done_o rises at the edge after the final byte of END_WORD (no checksum), or after the final checksum byte (with checksum).
- A byte and a timeout expiry in the same cycle: the byte wins, the counter clears and no error is set.
- Back-to-back bytes (rx_dv_i every cycle) are accepted at full rate in COLLECT.

## Configuration
- ICCM_LOADER_CHECKSUM_EN defined:
  - a DATA_W-bit running sum (mod 2^DATA_W) accumulates every written word at its handshake.
  - after END_WORD, state CHECK collects one more word, compares it against the sum, then goes to DONE.
  - on mismatch, err_o[2] is set. load_done_o is still set.
  - the timeout applies in CHECK as in COLLECT.
- Macro undefined:
  - no sum register and no CHECK state; END_WORD goes directly to DONE.
  - err_o[2] is tied to 0.

## Test plan
- Stream bytes DE AD BE EF, with wr_ready_i=1 -> one write of wdata 0xDEADBEEF at addr 0. Then addr_o=1, word_cnt_o=1, busy_o=0.
- Send two words, holding wr_ready_i=0 for 5 cycles on the first -> we_o stays high for 6 cycles with constant data. Second write goes to addr 1. No data is lost.
- Send 11 22, then idle TIMEOUT_CYC cycles (TIMEOUT_CYC=16), then send 33 44 55 66 -> err_o=3'b010. Write is 0x33445566 at addr 0.
- Send a byte during a stalled WRITE -> err_o[0]=1 and the byte is dropped. The next word is assembled from subsequent bytes only.
- Send 00 00 0F FF after two words -> no write, load_done_o=1. Further bytes are ignored. Assert rst_i -> all outputs return to reset values.
- With the macro, write 0x00000001 and 0x00000002, then send END_WORD and checksum 0x00000003 -> load_done_o=1, err_o=0. Repeat with checksum 0x00000004 -> err_o[2]=1.
